// File: rtl/axi_tdd_ng_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axi_tdd_ng_sync_gen (plus package axi_tdd_ng_pkg)
//  Purpose  : Sync source controller for the TDD engine. Merges an internal
//             periodic timer, an external sync pin and a software one-shot
//             into a single-cycle registered tdd_sync pulse. It also flags
//             syncs issued while the counter is not ARMED (sticky overrun)
//             and counts issued syncs.
//  Ports    :
//    clk                  in   TDD clock
//    resetn               in   asynchronous active-low reset
//    tdd_enable           in   block enable (shared with the TDD counter)
//    tdd_cstate           in   current TDD counter state
//    tdd_sync_int         in   internal periodic source enable
//    tdd_sync_ext         in   external source enable
//    tdd_sync_soft        in   software sync request (one-cycle pulse)
//    tdd_sync_period      in   internal period in cycles, 0 = timer off
//    sync_in              in   external sync pin, rising-edge active
//    tdd_sync_overrun_clr in   clears the overrun flag (one-cycle pulse)
//    tdd_sync             out  registered sync pulse to the counter
//    tdd_sync_overrun     out  sticky: sync issued while counter not ARMED
//    tdd_sync_count       out  syncs issued since enable (wraps)
//  Build option :
//    AXI_TDD_NG_SYNC_EXT_CDC_EN  - when defined, sync_in passes through a
//    2-flop synchronizer, so the pin may be asynchronous to clk and the
//    external path latency grows from 2 to 4 cycles.
//  Revision : 1.0 - initial release
// ============================================================================

package axi_tdd_ng_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;
endpackage

module axi_tdd_ng_sync_gen #(
    parameter int SYNC_COUNT_WIDTH  = 64,
    parameter int EVENT_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         tdd_enable,
    input  axi_tdd_ng_pkg::state_t       tdd_cstate,
    input  logic                         tdd_sync_int,
    input  logic                         tdd_sync_ext,
    input  logic                         tdd_sync_soft,
    input  logic [SYNC_COUNT_WIDTH-1:0]  tdd_sync_period,
    input  logic                         sync_in,
    input  logic                         tdd_sync_overrun_clr,
    output logic                         tdd_sync,
    output logic                         tdd_sync_overrun,
    output logic [EVENT_COUNT_WIDTH-1:0] tdd_sync_count
);

    localparam logic [SYNC_COUNT_WIDTH-1:0]  c_tmr_one = SYNC_COUNT_WIDTH'(1);
    localparam logic [EVENT_COUNT_WIDTH-1:0] c_cnt_one = EVENT_COUNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // External pin conditioning
    // ------------------------------------------------------------------------
    logic w_sync_in_pre;     // pin as seen by the input register
    logic r_sync_in_d;       // input register
    logic r_sync_in_hist;    // previous value, for rising-edge detection

`ifdef AXI_TDD_NG_SYNC_EXT_CDC_EN
    // Two-flop synchronizer; the pin may be asynchronous to clk. These flops
    // keep running regardless of tdd_enable so the chain is always settled.
    (* ASYNC_REG = "TRUE" *) logic r_cdc_meta;
    (* ASYNC_REG = "TRUE" *) logic r_cdc_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cdc_meta <= 1'b0;
            r_cdc_sync <= 1'b0;
        end else begin
            r_cdc_meta <= sync_in;
            r_cdc_sync <= r_cdc_meta;
        end
    end

    assign w_sync_in_pre = r_cdc_sync;
`else
    // Pin is synchronous to clk; feed the input register directly.
    assign w_sync_in_pre = sync_in;
`endif

    // The input register belongs to the pin path and is not cleared by
    // tdd_enable; only the edge history is.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync_in_d <= 1'b0;
        end else begin
            r_sync_in_d <= w_sync_in_pre;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync_in_hist <= 1'b0;
        end else if (!tdd_enable) begin
            r_sync_in_hist <= 1'b0;
        end else begin
            r_sync_in_hist <= r_sync_in_d;
        end
    end

    // ------------------------------------------------------------------------
    // Event sources
    // ------------------------------------------------------------------------
    logic [SYNC_COUNT_WIDTH-1:0] r_timer;
    logic [SYNC_COUNT_WIDTH-1:0] w_period_m1;
    logic                        w_tmr_en;
    logic                        w_int_event;
    logic                        w_ext_event;
    logic                        w_soft_event;
    logic                        w_any_event;

    assign w_tmr_en     = tdd_enable & tdd_sync_int & (tdd_sync_period != '0);
    assign w_period_m1  = tdd_sync_period - c_tmr_one;

    // Equality compare only: if the period shrinks below the current timer
    // value, the timer runs on to all-ones and wraps naturally.
    assign w_int_event  = w_tmr_en & (r_timer == w_period_m1);
    assign w_ext_event  = tdd_enable & tdd_sync_ext & r_sync_in_d & ~r_sync_in_hist;
    assign w_soft_event = tdd_enable & tdd_sync_soft;
    assign w_any_event  = w_int_event | w_ext_event | w_soft_event;

    // ------------------------------------------------------------------------
    // Period timer
    // Any issued sync (from any source) returns the timer to 0, so the timer
    // reads 0 in the cycle tdd_sync is high and the next internal sync lands
    // exactly one period after the last issued sync. The internal wrap is the
    // same mechanism, since an internal event is itself an issued sync.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (!w_tmr_en || w_any_event) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_tmr_one;
        end
    end

    // ------------------------------------------------------------------------
    // Merged sync pulse and issued-sync counter
    // Simultaneous events collapse into one pulse and one increment. All
    // events are already gated by tdd_enable, so a disabled block issues
    // nothing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdd_sync <= 1'b0;
        end else begin
            tdd_sync <= w_any_event;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdd_sync_count <= '0;
        end else if (!tdd_enable) begin
            tdd_sync_count <= '0;
        end else if (w_any_event) begin
            tdd_sync_count <= tdd_sync_count + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------------
    // Overrun flag
    // Sticky across tdd_enable; only reset or the clear pulse drops it. A new
    // overrun in the same cycle as a clear takes priority so it is never lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdd_sync_overrun <= 1'b0;
        end else if (w_any_event && (tdd_cstate != axi_tdd_ng_pkg::ARMED)) begin
            tdd_sync_overrun <= 1'b1;
        end else if (tdd_sync_overrun_clr) begin
            tdd_sync_overrun <= 1'b0;
        end
    end

endmodule

`default_nettype wire
